scan_cmd_queue: RTL and testbench
=================================

Name: scan_cmd_queue

Overview:
- Command buffer between the UART scan-chain client (producer) and the scan-chain serialiser (consumer).
- Stores complete write commands: address, payload and reset flag. The UART client can accept the next command while a slow scan shift (1 kHz scan clock) is still in progress.
- Exposes occupancy and a sticky backpressure flag for LED/debug.
- Sits in the FPGA top between the UART client and the writer; all in the 100 MHz FPGA clock domain.

Parameters:
- ADDR_BITS, 12, width of the scan address field
- PAYLOAD_BITS, 169, width of the scan payload field
- DEPTH, 4, number of command entries; power of two, >= 2
- PTR_BITS, $clog2(DEPTH), read/write pointer width (derived, not overridden)

Ports:
- clk  in  1  FPGA clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a command
- in_ready  out  1  queue can accept a command this cycle
- in_addr  in  ADDR_BITS  command address
- in_payload  in  PAYLOAD_BITS  command payload
- in_reset  in  1  command is a scan-chain reset request
- out_valid  out  1  head entry is valid
- out_ready  in  1  consumer takes the head entry this cycle
- out_addr  out  ADDR_BITS  head address
- out_payload  out  PAYLOAD_BITS  head payload
- out_reset  out  1  head reset flag
- flush  in  1  synchronous discard of all entries
- count  out  PTR_BITS+1  current occupancy, 0..DEPTH
- stall_seen  out  1  sticky: producer was backpressured
- clear_stall  in  1  clears stall_seen

Behaviour:
- Reset (async, active-high). Immediately:
  - count = 0, out_valid = 0, in_ready = 1, stall_seen = 0.
  - All storage, pointers and out_* data fields = 0.
- Handshakes:
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - Transfers occur on the rising clk edge.
- in_ready = (count != DEPTH) & ~flush.
  - Depends only on registered state and flush.
  - No combinational path from out_ready to in_ready; no pass-through when full.
- out_valid = (count != 0).
  - out_* are driven from the head entry: first-word fall-through, read mux from registered storage.
- Latency: a command pushed at edge N gives out_valid = 1 with its fields after edge N, i.e. visible in cycle N+1.
- Stability: while out_valid & ~out_ready, out_addr, out_payload and out_reset must not change.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full/empty is decided by count, not pointer equality.
- Full (count == DEPTH):
  - in_ready = 0.
  - Same-cycle pop frees a slot; in_ready rises the next cycle.
- Empty (count == 0): out_valid = 0; out_ready is ignored; no underflow.
- Flush:
  - At the edge where flush = 1: pointers and count go to 0, and any pop that cycle is ignored.
  - in_ready is 0 during flush, so no push occurs.
  - stall_seen is unaffected.
- stall_seen:
  - Set at the edge where in_valid & ~in_ready & ~flush.
  - Cleared by clear_stall.
  - Set takes priority over clear in the same cycle.
- Field packing in storage is {reset, addr, payload}, fixed.
- Entry width = ADDR_BITS + PAYLOAD_BITS + 1.

Decomposition:
- Shared package scanchain_pkg:
  - SC_ADDR_BITS = 12, SC_PAYLOAD_BITS = 169.
  - SC_ENTRY_BITS.
  - Packed struct/typedef scan_cmd_t {reset, addr, payload}.
  - Used by the queue, the UART client and the writer.
- One sub-module: scan_cmd_mem. DEPTH x SC_ENTRY_BITS register array with:
  - one write port (we, waddr, wdata), clocked;
  - one async read port (raddr -> rdata);
  - async reset to 0.
- Control (pointers, count, flags) stays in scan_cmd_queue.

Test Plan:
- Reset, then single push addr=0x0A5, payload=169'h1, reset=0 -> next cycle: out_valid=1, out_addr=0x0A5, count=1; pop -> out_valid=0, count=0.
- Push 4 commands (addr 1..4) with out_ready=0 -> count=4, in_ready=0; hold in_valid=1 one cycle -> stall_seen=1; pop 4 -> out_addr in order 1,2,3,4.
- Full queue, simultaneous in_valid and out_ready -> no push that cycle, count=3, in_ready=1 next cycle; then the held command (addr 5) is accepted.
- Steady stream with in_valid=out_ready=1 for 10 cycles at count=2 -> count stays 2, pointers wrap past DEPTH, data order preserved.
- count=3, assert flush together with in_valid and out_ready -> count=0, out_valid=0, no entry accepted; clear_stall with a stall event in the same cycle -> stall_seen stays 1.
- Assert reset mid-stream at count=2 -> count=0, out_valid=0, out_addr=0 immediately (async, before next edge); in_ready=1.

Source files
------------

// File: rtl/scanchain_pkg.sv
// Shared scan-chain command types used by the UART client, queue and writer.
// Fixed field widths and the packed command layout {reset, addr, payload}.
package scanchain_pkg;

    localparam int SC_ADDR_BITS    = 12;
    localparam int SC_PAYLOAD_BITS = 169;
    localparam int SC_ENTRY_BITS   = SC_ADDR_BITS + SC_PAYLOAD_BITS + 1;

    typedef struct packed {
        logic                       reset;
        logic [SC_ADDR_BITS-1:0]    addr;
        logic [SC_PAYLOAD_BITS-1:0] payload;
    } scan_cmd_t;

endpackage

// File: rtl/scan_cmd_mem.sv
// Command storage: DEPTH x WIDTH registers, one clocked write port, one async read.
// Ports: clk, reset (async, high), we/waddr/wdata write, raddr -> rdata read.
module scan_cmd_mem
    import scanchain_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = SC_ENTRY_BITS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/scan_cmd_queue.sv
// Scan command FIFO between UART client and scan serialiser (first-word fall-through).
// Ports: in_* push handshake, out_* pop handshake, flush, count, sticky stall_seen.
module scan_cmd_queue
    import scanchain_pkg::*;
#(
    parameter int ADDR_BITS    = SC_ADDR_BITS,
    parameter int PAYLOAD_BITS = SC_PAYLOAD_BITS,
    parameter int DEPTH        = 4,
    parameter int PTR_BITS     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_BITS-1:0]    in_addr,
    input  logic [PAYLOAD_BITS-1:0] in_payload,
    input  logic                    in_reset,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_BITS-1:0]    out_addr,
    output logic [PAYLOAD_BITS-1:0] out_payload,
    output logic                    out_reset,
    input  logic                    flush,
    output logic [PTR_BITS:0]       count,
    output logic                    stall_seen,
    input  logic                    clear_stall
);

    localparam int ENTRY_BITS = ADDR_BITS + PAYLOAD_BITS + 1;
    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS + 1)'(DEPTH);

    logic [PTR_BITS-1:0]   wptr;
    logic [PTR_BITS-1:0]   rptr;
    logic [ENTRY_BITS-1:0] wdata;
    logic [ENTRY_BITS-1:0] rdata;
    logic                  push;
    logic                  pop;
    logic                  full;

    assign full      = (count == FULL_CNT);
    assign in_ready  = ~full & ~flush;
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    // A flush wins over a pop in the same cycle.
    assign pop       = out_valid & out_ready & ~flush;

    assign wdata = {in_reset, in_addr, in_payload};
    assign {out_reset, out_addr, out_payload} = rdata;

    scan_cmd_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_BITS),
        .AW    (PTR_BITS)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (push),
        .waddr (wptr),
        .wdata (wdata),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_BITS'(1);
            if (pop)  rptr <= rptr + PTR_BITS'(1);
            if (push & ~pop) begin
                count <= count + (PTR_BITS + 1)'(1);
            end else if (pop & ~push) begin
                count <= count - (PTR_BITS + 1)'(1);
            end
        end
    end

    // Setting beats clearing so a stall in the clear cycle is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_seen <= 1'b0;
        end else if (in_valid & ~in_ready & ~flush) begin
            stall_seen <= 1'b1;
        end else if (clear_stall) begin
            stall_seen <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_cmd_queue.sv
// Randomised + directed bench for scan_cmd_queue against a queue-based model.
// No ports; drives on negedge, checks combinational outputs before posedge.
module tb_scan_cmd_queue;
    import scanchain_pkg::*;

    localparam int DEPTH = 4;
    localparam int PB    = 2;

    logic                       clk;
    logic                       reset;
    logic                       in_valid;
    logic                       in_ready;
    logic [SC_ADDR_BITS-1:0]    in_addr;
    logic [SC_PAYLOAD_BITS-1:0] in_payload;
    logic                       in_reset;
    logic                       out_valid;
    logic                       out_ready;
    logic [SC_ADDR_BITS-1:0]    out_addr;
    logic [SC_PAYLOAD_BITS-1:0] out_payload;
    logic                       out_reset;
    logic                       flush;
    logic [PB:0]                count;
    logic                       stall_seen;
    logic                       clear_stall;

    scan_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_payload  (in_payload),
        .in_reset    (in_reset),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_payload (out_payload),
        .out_reset   (out_reset),
        .flush       (flush),
        .count       (count),
        .stall_seen  (stall_seen),
        .clear_stall (clear_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_tests = 0;
    int        n_fail  = 0;
    scan_cmd_t q[$];
    bit        stall_m = 1'b0;

    task automatic check(input string tag, input logic [199:0] got,
                         input logic [199:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        check("in_ready", in_ready, (q.size() != DEPTH) && !flush);
        check("out_valid", out_valid, q.size() != 0);
        check("count", count, q.size());
        check("stall_seen", stall_seen, stall_m);
        if (q.size() != 0) begin
            check("out_addr", out_addr, q[0].addr);
            check("out_payload", out_payload, q[0].payload);
            check("out_reset", out_reset, q[0].reset);
        end
    endtask

    task automatic set_in(input bit v, input logic [SC_ADDR_BITS-1:0] a,
                          input logic [SC_PAYLOAD_BITS-1:0] p, input bit r,
                          input bit ordy, input bit fl, input bit clr);
        in_valid    = v;
        in_addr     = a;
        in_payload  = p;
        in_reset    = r;
        out_ready   = ordy;
        flush       = fl;
        clear_stall = clr;
    endtask

    // Check now, then advance the model across one rising edge.
    task automatic step();
        bit        rdy;
        bit        do_push;
        bit        do_pop;
        scan_cmd_t c;
        #1;
        check_outs();
        rdy     = (q.size() != DEPTH) && !flush;
        do_push = in_valid && rdy;
        do_pop  = (q.size() != 0) && out_ready && !flush;
        c       = '{reset: in_reset, addr: in_addr, payload: in_payload};
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(c);
        end
        if (in_valid && !rdy && !flush) stall_m = 1'b1;
        else if (clear_stall)           stall_m = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [SC_PAYLOAD_BITS-1:0] rand_payload();
        logic [191:0] w;
        w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return w[SC_PAYLOAD_BITS-1:0];
    endfunction

    initial begin
        reset = 1'b1;
        set_in(0, '0, '0, 0, 0, 0, 0);
        #2;
        check_outs();
        check("rst_out_addr", out_addr, 0);
        check("rst_out_payload", out_payload, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single push then pop
        set_in(1, 12'h0A5, 169'h1, 0, 0, 0, 0);
        step();
        set_in(0, '0, '0, 0, 1, 0, 0);
        step();
        set_in(0, '0, '0, 0, 0, 0, 0);
        step();

        // fill to full, stall, then full with simultaneous pop
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 12'(i), rand_payload(), i[0], 0, 0, 0);
            step();
        end
        set_in(1, 12'd5, 169'h55, 1, 0, 0, 0);
        step();
        set_in(1, 12'd5, 169'h55, 1, 1, 0, 0);
        step();
        set_in(1, 12'd5, 169'h55, 1, 0, 0, 0);
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(0, '0, '0, 0, 1, 0, 0);
            step();
        end

        // steady stream at count 2
        for (int i = 0; i < 2; i++) begin
            set_in(1, 12'(10 + i), rand_payload(), 0, 0, 0, 0);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1, 12'(20 + i), rand_payload(), 1, 1, 0, 0);
            step();
        end

        // flush at count 3 with push and pop requested
        set_in(1, 12'h111, rand_payload(), 0, 0, 0, 0);
        step();
        set_in(1, 12'h222, rand_payload(), 0, 1, 1, 0);
        step();
        set_in(0, '0, '0, 0, 0, 0, 0);
        step();

        // clear_stall in the same cycle as a stall keeps the flag
        for (int i = 0; i < 5; i++) begin
            set_in(1, 12'(40 + i), rand_payload(), 0, 0, 0, i == 4);
            step();
        end
        set_in(0, '0, '0, 0, 0, 0, 1);
        step();
        set_in(0, '0, '0, 0, 1, 0, 0);
        step();
        step();

        // async reset mid-stream at count 2
        set_in(0, '0, '0, 0, 0, 0, 0);
        #1;
        check("pre_rst_count", count, 2);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        stall_m = 1'b0;
        check("arst_count", count, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_addr", out_addr, 0);
        check("arst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 12'($urandom),
                   rand_payload(), 1'($urandom),
                   $urandom_range(0, 2) != 0,
                   $urandom_range(0, 15) == 0,
                   $urandom_range(0, 7) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
